matrix_result_streamer: RTL and testbench
=========================================

Name: matrix_result_streamer

Overview:
- Unloads a completed result matrix from the matrix-multiplication datapath.
- Captures the flattened N x M result bus in one cycle on a load pulse, then streams the elements out one per transfer, in row-major order, over a valid/ready interface with row/column tags and a last flag.
- It is the output-side counterpart of the input registering stage: the register captures operands in, and this block drains results out.

Parameters:
- DATA_WIDTH, 18, width of one matrix element in bits.
- N, 3, number of result rows (N >= 1).
- M, 3, number of result columns (M >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle pulse; result_flat is valid in this cycle.
- result_flat  input  N*M*DATA_WIDTH  flattened result; element k = row*M+col occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- out_data  output  DATA_WIDTH  current element.
- out_valid  output  1  out_data, out_row, out_col and out_last are valid.
- out_ready  input  1  downstream accepts the current element.
- out_row  output  max(1,$clog2(N))  row index of out_data.
- out_col  output  max(1,$clog2(M))  column index of out_data.
- out_last  output  1  high with the element k = N*M-1.
- busy  output  1  high whenever state is STREAM.
- overrun  output  1  one-cycle pulse when a load is dropped.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; shadow buffer cleared to 0; out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overrun=0.
- State IDLE:
  - load=1 captures all of result_flat into the internal shadow buffer and sets row=0, col=0.
  - Transition to STREAM at the next edge.
  - out_valid rises on the cycle after load (latency 1).
  - load=0 leaves the block in IDLE.
- State STREAM:
  - out_valid=1 and busy=1 throughout.
  - out_data = shadow[row*M+col]; out_last = (row==N-1 && col==M-1).
- Transfer occurs when out_valid && out_ready at a rising edge. After a transfer:
  - col increments.
  - When col==M-1, col wraps to 0 and row increments.
  - After the last element, return to IDLE and drop out_valid on the next cycle.
- Hold rule: while out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last stay stable. No element is skipped or repeated.
- out_ready is ignored while in IDLE.
- load during STREAM with no final transfer in that cycle:
  - The load is dropped; the shadow buffer is unchanged.
  - overrun pulses high for exactly one cycle, on the following cycle.
- load in the same cycle as the final transfer (out_last && out_ready):
  - The new matrix is captured, row=0, col=0, and the block stays in STREAM.
  - out_valid stays high with no bubble; the next element is new element 0.
  - No overrun is raised.
- Throughput: one element per cycle while out_ready is held high. A full matrix takes N*M consecutive valid cycles.
- Degenerate size N=M=1: a single element with out_last=1.
- Reset asserted mid-stream: the stream is abandoned immediately and all outputs return to their reset values. After reset releases, the block waits in IDLE for a new load.
- result_flat is sampled only in a cycle where load is accepted; it is don't-care at all other times.
- All outputs are registered; there is no combinational path from out_ready to out_valid or out_data.

Test Plan:
- Basic stream, N=M=3, DATA_WIDTH=18, result_flat elements k = 0x100+k, out_ready=1:
  - load pulse → out_valid rises 1 cycle later.
  - out_data runs 0x100..0x108 on 9 consecutive cycles.
  - (row,col) runs (0,0),(0,1),(0,2),(1,0)..(2,2).
  - out_last is high only with 0x108; out_valid=0 on the cycle after.
- Backpressure, same data, out_ready toggled 1,0,0,1,0,1...:
  - Every element 0x100..0x108 is delivered exactly once, in order.
  - out_data and out_row/out_col are held stable during every ready=0 cycle.
- Overrun: second load with element values 0x200+k at the 4th transfer of the first stream:
  - overrun pulses for one cycle.
  - The stream continues 0x104..0x108 unchanged; the block returns to IDLE.
- Back-to-back: second load (0x200+k) asserted in the cycle that 0x108 transfers with out_ready=1:
  - out_valid never drops; 0x200 follows 0x108 on the next cycle.
  - No overrun pulse.
- Reset mid-stream: rst=0 after 5 transfers:
  - out_valid, busy, out_data, out_row and out_col go to 0 without waiting for a clock edge.
  - After release, a fresh load of 0x300+k streams correctly starting at (0,0).
- Parameter variant N=2, M=4, with out_ready=1 and a load of elements 0x10+k:
  - Tags run (0,0)..(0,3),(1,0)..(1,3); out_data runs 0x10..0x17.
  - out_last is high only with 0x17.

Source files
------------

// File: rtl/matrix_result_streamer.sv
// Drains a captured N x M result matrix as a row-major valid/ready element stream
// with row/column tags, a last flag and a dropped-load indicator.
module matrix_result_streamer #(
  parameter int DATA_WIDTH = 18,
  parameter int N          = 3,
  parameter int M          = 3,
  localparam int RW        = (N > 1) ? $clog2(N) : 1,
  localparam int CW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic [N*M*DATA_WIDTH-1:0]    i_result_flat,
  output logic [DATA_WIDTH-1:0]        o_out_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [RW-1:0]                o_out_row,
  output logic [CW-1:0]                o_out_col,
  output logic                         o_out_last,
  output logic                         o_busy,
  output logic                         o_overrun
);
  localparam int NE = N * M;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                        r_state, w_state_nxt;
  logic [NE-1:0][DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0]         r_data;
  logic [RW-1:0]                 r_row;
  logic [CW-1:0]                 r_col;
  logic [IW-1:0]                 r_idx;
  logic                          r_last;
  logic                          r_overrun;

  logic                          w_capture, w_advance, w_drop;
  logic [IW-1:0]                 w_nidx;
  logic                          w_nlast;
  logic [DATA_WIDTH-1:0]         w_next_data;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_capture   = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_out_ready && r_last) begin
          // A load coinciding with the final transfer chains the next matrix with no bubble.
          if (i_load) w_capture   = 1'b1;
          else        w_state_nxt = S_IDLE;
        end else begin
          w_advance = i_out_ready;
          w_drop    = i_load;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  assign w_nidx  = r_idx + IW'(1);
  assign w_nlast = (int'(w_nidx) == NE - 1);

  always_comb begin
    w_next_data = '0;
    for (int k = 0; k < NE; k++)
      if (k == int'(w_nidx)) w_next_data = r_shadow[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow  <= '0;
      r_data    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_capture) begin
        r_shadow <= i_result_flat;
        r_data   <= i_result_flat[DATA_WIDTH-1:0];
        r_row    <= '0;
        r_col    <= '0;
        r_idx    <= '0;
        r_last   <= (NE == 1);
      end else if (w_advance) begin
        r_idx  <= w_nidx;
        r_data <= w_next_data;
        r_last <= w_nlast;
        if (r_col == CW'(M - 1)) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign o_out_valid = (r_state == S_STREAM);
  assign o_busy      = (r_state == S_STREAM);
  assign o_out_data  = r_data;
  assign o_out_row   = r_row;
  assign o_out_col   = r_col;
  assign o_out_last  = r_last;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: queue-based stream model for a 3x3 instance,
// plus directed literal checks on 3x3, 2x4 and 1x1 instances.
module tb_matrix_result_streamer;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 3x3 main instance
  logic          load = 1'b0, ready = 1'b0;
  logic [9*DW-1:0] flat = '0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_last, o_busy, o_ovr;
  logic [1:0]    o_row, o_col;

  matrix_result_streamer #(.DATA_WIDTH(DW), .N(3), .M(3)) u_dut (
    .clk(clk), .rst(rst), .i_load(load), .i_result_flat(flat),
    .o_out_data(o_data), .o_out_valid(o_valid), .i_out_ready(ready),
    .o_out_row(o_row), .o_out_col(o_col), .o_out_last(o_last),
    .o_busy(o_busy), .o_overrun(o_ovr));

  // 2x4 variant
  logic          load2 = 1'b0, ready2 = 1'b0;
  logic [8*DW-1:0] flat2 = '0;
  logic [DW-1:0] o_data2;
  logic          o_valid2, o_last2, o_busy2, o_ovr2;
  logic [0:0]    o_row2;
  logic [1:0]    o_col2;

  matrix_result_streamer #(.DATA_WIDTH(DW), .N(2), .M(4)) u_dut2 (
    .clk(clk), .rst(rst), .i_load(load2), .i_result_flat(flat2),
    .o_out_data(o_data2), .o_out_valid(o_valid2), .i_out_ready(ready2),
    .o_out_row(o_row2), .o_out_col(o_col2), .o_out_last(o_last2),
    .o_busy(o_busy2), .o_overrun(o_ovr2));

  // 1x1 degenerate
  logic          load1 = 1'b0, ready1 = 1'b0;
  logic [DW-1:0] flat1 = '0;
  logic [DW-1:0] o_data1;
  logic          o_valid1, o_last1, o_busy1, o_ovr1;
  logic [0:0]    o_row1, o_col1;

  matrix_result_streamer #(.DATA_WIDTH(DW), .N(1), .M(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_load(load1), .i_result_flat(flat1),
    .o_out_data(o_data1), .o_out_valid(o_valid1), .i_out_ready(ready1),
    .o_out_row(o_row1), .o_out_col(o_col1), .o_out_last(o_last1),
    .o_busy(o_busy1), .o_overrun(o_ovr1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the queue holds the elements still owed downstream; its front is what must be shown.
  typedef struct { logic [DW-1:0] d; int r; int c; bit l; } el_t;
  el_t q[$];
  logic exp_ovr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      exp_ovr <= 1'b0;
    end else begin
      int sz;
      sz = q.size();
      exp_ovr <= 1'b0;
      if (sz > 0 && ready) void'(q.pop_front());
      if (load) begin
        if (sz == 0 || (sz == 1 && ready)) begin
          for (int k = 0; k < 9; k++) begin
            el_t e;
            e.d = flat[k*DW +: DW];
            e.r = k / 3;
            e.c = k % 3;
            e.l = (k == 8);
            q.push_back(e);
          end
        end else begin
          exp_ovr <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_valid", 32'(o_valid), 32'(q.size() > 0));
      chk("m_busy", 32'(o_busy), 32'(q.size() > 0));
      chk("m_overrun", 32'(o_ovr), 32'(exp_ovr));
      if (q.size() > 0) begin
        chk("m_data", 32'(o_data), 32'(q[0].d));
        chk("m_row", 32'(o_row), q[0].r);
        chk("m_col", 32'(o_col), q[0].c);
        chk("m_last", 32'(o_last), 32'(q[0].l));
      end
    end
  end

  // Delivered-element log; ready is stable across the following edge, so this records transfers.
  logic [DW-1:0] got[$];
  always @(negedge clk)
    if (rst && o_valid && ready) got.push_back(o_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flat(input int base);
    for (int k = 0; k < 9; k++) flat[k*DW +: DW] = DW'(base + k);
  endtask

  task automatic chk_got(input string nm, input int n, input int b0, input int b1);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++)
      chk(nm, 32'(got[i]), (i < 9) ? b0 + i : b1 + i - 9);
    got.delete();
  endtask

  initial begin
    bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    #2;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_rowcol", {o_row, o_col}, 0);
    chk("rst_last_ovr", {o_last, o_ovr}, 0);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // Basic stream
    set_flat(32'h100); ready = 1'b1;
    tick(); load = 1'b1;
    @(negedge clk) chk("lat_valid0", 32'(o_valid), 0);
    tick(); load = 1'b0;
    @(negedge clk);
    chk("lat_valid1", 32'(o_valid), 1);
    chk("first_data", 32'(o_data), 32'h100);
    repeat (8) tick();
    @(negedge clk);
    chk("last_data", 32'(o_data), 32'h108);
    chk("last_flag", 32'(o_last), 1);
    chk("last_rowcol", {o_row, o_col}, 32'b1010);
    tick();
    @(negedge clk) chk("end_valid", 32'(o_valid), 0);
    repeat (2) tick();
    chk_got("basic", 9, 32'h100, 0);

    // Backpressure
    load = 1'b1;
    tick(); load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ready = pat[i % 8];
      tick();
    end
    ready = 1'b1;
    repeat (4) tick();
    chk_got("bp", 9, 32'h100, 0);

    // Overrun during stream
    set_flat(32'h100);
    load = 1'b1;
    tick(); load = 1'b0;
    repeat (3) tick();
    set_flat(32'h200); load = 1'b1;
    tick(); load = 1'b0;
    @(negedge clk) chk("ovr_pulse", 32'(o_ovr), 1);
    tick();
    @(negedge clk) chk("ovr_clear", 32'(o_ovr), 0);
    repeat (8) tick();
    chk_got("ovr", 9, 32'h100, 0);

    // Back-to-back chained load
    set_flat(32'h100);
    load = 1'b1;
    tick(); load = 1'b0;
    repeat (8) tick();
    set_flat(32'h200); load = 1'b1;
    tick(); load = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 32'(o_valid), 1);
    chk("b2b_data", 32'(o_data), 32'h200);
    chk("b2b_ovr", 32'(o_ovr), 0);
    repeat (10) tick();
    chk_got("b2b", 18, 32'h100, 32'h200);

    // Reset mid-stream
    set_flat(32'h100);
    load = 1'b1;
    tick(); load = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(o_valid), 0);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_data", 32'(o_data), 0);
    chk("mrst_rowcol", {o_row, o_col}, 0);
    tick(); rst = 1'b1;
    got.delete();
    tick();
    set_flat(32'h300); load = 1'b1;
    tick(); load = 1'b0;
    @(negedge clk) chk("mrst_first_rowcol", {o_row, o_col}, 0);
    repeat (10) tick();
    chk_got("mrst", 9, 32'h300, 0);

    // 2x4 variant
    for (int k = 0; k < 8; k++) flat2[k*DW +: DW] = DW'(32'h10 + k);
    ready2 = 1'b1; load2 = 1'b1;
    tick(); load2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("v_valid", 32'(o_valid2), 1);
      chk("v_data", 32'(o_data2), 32'h10 + k);
      chk("v_row", 32'(o_row2), k / 4);
      chk("v_col", 32'(o_col2), k % 4);
      chk("v_last", 32'(o_last2), 32'(k == 7));
      tick();
    end
    @(negedge clk) chk("v_end_valid", 32'(o_valid2), 0);

    // 1x1 degenerate
    tick();
    flat1 = 18'h155; ready1 = 1'b1; load1 = 1'b1;
    tick(); load1 = 1'b0;
    @(negedge clk);
    chk("d_valid", 32'(o_valid1), 1);
    chk("d_data", 32'(o_data1), 32'h155);
    chk("d_last", 32'(o_last1), 1);
    chk("d_rowcol", {o_row1, o_col1}, 0);
    tick();
    @(negedge clk) chk("d_end_valid", 32'(o_valid1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
